// File: rtl/spi_readout_word_packer_if.sv
// Byte-in / word-out bus of the SPI readout word packer.
// slave = packer side, master = byte source plus FIFO write port.
interface spi_readout_word_packer_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        fifo_full;
    logic [63:0] fifo_din;
    logic        fifo_wr_en;

    modport master (output byte_valid, byte_data, fifo_full,
                    input  fifo_din, fifo_wr_en);
    modport slave  (input  byte_valid, byte_data, fifo_full,
                    output fifo_din, fifo_wr_en);
endinterface

// File: rtl/spi_readout_word_packer.sv
// Packs the SPI MISO byte stream into 64-bit SPI read FIFO words; byte 0 is the LSB.
// Optional SPI_PACK_IDLE_FILTER_EN discards IDLE_BYTE codes before packing.
module spi_readout_word_packer #(
    parameter logic [7:0] IDLE_BYTE      = 8'hBC,
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter int         CNT_W          = 16
) (
    input  logic                 i_clk,
    input  logic                 i_res_n,
    input  logic                 i_enable,
    input  logic                 i_flush_req,
    input  logic                 i_clear_drops,
    spi_readout_word_packer_if.slave bus,
    output logic [CNT_W-1:0]     o_drop_count,
    output logic                 o_busy
);
    localparam logic [0:0]       ST_ACC  = 1'b0;
    localparam logic [0:0]       ST_EMIT = 1'b1;
    localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TIMEOUT_CYCLES);
    localparam bit               TMO_EN  = (TIMEOUT_CYCLES != 0);

    logic [0:0]       r_state;
    logic [2:0]       r_cnt;
    logic [63:0]      r_word;
    logic [CNT_W-1:0] r_tmo;
    logic [CNT_W-1:0] r_drops;

    logic        w_byte_in;
    logic        w_wr;
    logic        w_accept;
    logic        w_drop;
    logic [2:0]  w_slot;
    logic [3:0]  w_fill;
    logic        w_tmo_hit;
    logic        w_flush;
    logic        w_to_emit;
    logic [63:0] w_word_nxt;

`ifdef SPI_PACK_IDLE_FILTER_EN
    assign w_byte_in = bus.byte_valid & i_enable & (bus.byte_data != IDLE_BYTE);
`else
    assign w_byte_in = bus.byte_valid & i_enable;
`endif

    assign w_wr     = (r_state == ST_EMIT) & ~bus.fifo_full;
    assign w_accept = w_byte_in & ((r_state == ST_ACC) | w_wr);
    assign w_drop   = w_byte_in & ~w_accept;

    // A byte taken during the write cycle starts the next word at slot 0.
    assign w_slot    = (r_state == ST_ACC) ? r_cnt : 3'd0;
    assign w_fill    = {1'b0, w_slot} + {3'd0, w_accept};
    assign w_tmo_hit = TMO_EN && (r_state == ST_ACC) && (r_cnt != 3'd0) &&
                       (r_tmo == TMO_LIM) && !w_accept;
    assign w_flush   = (r_state == ST_ACC) & (i_flush_req | w_tmo_hit) & (w_fill != 4'd0);
    assign w_to_emit = (r_state == ST_ACC) & (w_fill[3] | w_flush);

    always_comb begin
        w_word_nxt = r_word;
        if (w_accept)
            w_word_nxt[{w_slot, 3'b000} +: 8] = bus.byte_data;
        for (int k = 0; k < 8; k++) begin
            if (w_flush && (4'(k) >= w_fill))
                w_word_nxt[8*k +: 8] = IDLE_BYTE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_res_n) begin
            r_state <= ST_ACC;
            r_cnt   <= 3'd0;
            r_word  <= 64'h0;
            r_tmo   <= '0;
            r_drops <= '0;
        end else begin
            r_word <= w_word_nxt;
            if (w_to_emit)
                r_state <= ST_EMIT;
            else if (w_wr)
                r_state <= ST_ACC;
            r_cnt <= w_to_emit ? 3'd0 : w_fill[2:0];

            if (TMO_EN && (r_state == ST_ACC) && !w_to_emit && !w_accept && (r_cnt != 3'd0))
                r_tmo <= r_tmo + 1'b1;
            else
                r_tmo <= '0;

            // Clearing in a drop cycle still records that drop.
            if (i_clear_drops)
                r_drops <= {{(CNT_W-1){1'b0}}, w_drop};
            else if (w_drop && !(&r_drops))
                r_drops <= r_drops + 1'b1;
        end
    end

    assign bus.fifo_din   = r_word;
    assign bus.fifo_wr_en = w_wr;
    assign o_drop_count   = r_drops;
    assign o_busy         = (r_state == ST_EMIT) | (r_cnt != 3'd0);
endmodule
